// File: rtl/ifetch_ctrl_if.sv
// Fetch-unit bus bundle: instruction RAM request/response port plus the decode-side valid/ready port.
interface ifetch_ctrl_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic            instr_req;
  logic            instr_write;
  logic [DW/8-1:0] instr_wstrb;
  logic [DW-1:0]   instr_wdata;
  logic [AW-1:0]   instr_addr;
  logic            instr_addr_ok;
  logic            instr_data_ok;
  logic [DW-1:0]   instr_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_instr;
  logic [31:0]     out_pc;

  modport master (
    output instr_req, instr_write, instr_wstrb, instr_wdata, instr_addr,
    input  instr_addr_ok, instr_data_ok, instr_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  instr_req, instr_write, instr_wstrb, instr_wdata, instr_addr,
    output instr_addr_ok, instr_data_ok, instr_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch front end: sequential PC generation, in-flight PC tracking,
// output FIFO toward decode, and redirect flush with drop of stale responses.
module ifetch_ctrl #(
  parameter int          AW       = 12,
  parameter int          DW       = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          FIFO_DEP = 4,
  parameter int          MAX_OS   = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  ifetch_ctrl_if.master bus
);
  localparam int CW  = $clog2(MAX_OS + 1) + 1;
  localparam int FPW = $clog2(FIFO_DEP);
  localparam int QPW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;

  logic            run_q, run_d;
  logic            pend_q, pend_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            redir_vld_q, redir_vld_d;
  logic [31:0]     redir_pc_q, redir_pc_d;
  logic [CW-1:0]   os_cnt_q, os_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [QPW-1:0]  pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [FPW:0]    fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  logic [31:0]     pcq_q        [MAX_OS];
  logic [DW-1:0]   fifo_instr_q [FIFO_DEP];
  logic [31:0]     fifo_pc_q    [FIFO_DEP];

  logic [FPW:0]    fifo_cnt;
  logic            req, accept, resp, keep, pop;
  logic [31:0]     redir_tgt;

  function automatic logic [QPW-1:0] qinc(input logic [QPW-1:0] p);
    return (int'(p) == MAX_OS - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_cnt  = fifo_wr_q - fifo_rd_q;
    // FIFO slots are reserved for every outstanding request, so a response can always be stored.
    req       = run_q & (pend_q | (((int'(os_cnt_q) + int'(fifo_cnt)) < FIFO_DEP)
                                   && (int'(os_cnt_q) < MAX_OS)));
    accept    = req & bus.instr_addr_ok;
    resp      = bus.instr_data_ok & (os_cnt_q != '0);
    keep      = resp & (drop_cnt_q == '0);
    pop       = (fifo_cnt != '0) & bus.out_ready;
    redir_tgt = {redirect_pc[31:2], 2'b00};

    run_d       = 1'b1;
    pend_d      = req & ~bus.instr_addr_ok;
    os_cnt_d    = os_cnt_q + CW'(accept) - CW'(resp);
    drop_cnt_d  = drop_cnt_q - CW'(resp && (drop_cnt_q != '0));
    pcq_wr_d    = accept ? qinc(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d    = resp   ? qinc(pcq_rd_q) : pcq_rd_q;
    fifo_wr_d   = fifo_wr_q + (FPW + 1)'(keep);
    fifo_rd_d   = fifo_rd_q + (FPW + 1)'(pop);
    fetch_pc_d  = fetch_pc_q;
    redir_vld_d = redir_vld_q;
    redir_pc_d  = redir_pc_q;

    if (accept) begin
      fetch_pc_d  = redir_vld_q ? redir_pc_q : fetch_pc_q + 32'd4;
      redir_vld_d = 1'b0;
    end

    // Every request already accepted or still pending is stale; the target PC waits for the
    // pending request to be accepted so instr_addr never changes while instr_req is held.
    if (redirect) begin
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      drop_cnt_d = os_cnt_d + CW'(pend_d);
      if (pend_d) begin
        redir_vld_d = 1'b1;
        redir_pc_d  = redir_tgt;
      end else begin
        redir_vld_d = 1'b0;
        fetch_pc_d  = redir_tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      run_q       <= 1'b0;
      pend_q      <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      os_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      pcq_wr_q    <= '0;
      pcq_rd_q    <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
    end else begin
      run_q       <= run_d;
      pend_q      <= pend_d;
      fetch_pc_q  <= fetch_pc_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
      os_cnt_q    <= os_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      pcq_wr_q    <= pcq_wr_d;
      pcq_rd_q    <= pcq_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pcq_q[pcq_wr_q] <= fetch_pc_q;
    if (keep) begin
      fifo_instr_q[fifo_wr_q[FPW-1:0]] <= bus.instr_rdata;
      fifo_pc_q[fifo_wr_q[FPW-1:0]]    <= pcq_q[pcq_rd_q];
    end
  end

  assign bus.instr_req   = req;
  assign bus.instr_write = 1'b0;
  assign bus.instr_wstrb = '0;
  assign bus.instr_wdata = '0;
  assign bus.instr_addr  = fetch_pc_q[AW+1:2];
  assign bus.out_valid   = (fifo_cnt != '0);
  assign bus.out_instr   = fifo_instr_q[fifo_rd_q[FPW-1:0]];
  assign bus.out_pc      = fifo_pc_q[fifo_rd_q[FPW-1:0]];

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_b)
    bus.instr_data_ok |-> (os_cnt_q != '0));
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: RAM responder model, expected-stream queue and output monitor.
module tb_ifetch_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;

  logic        clk;
  logic        rst_b;
  logic        redirect;
  logic [31:0] redirect_pc;

  ifetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  ifetch_ctrl #(
    .AW(AW), .DW(DW), .RESET_PC(32'h0), .FIFO_DEP(4), .MAX_OS(2)
  ) dut (
    .clk(clk), .rst_b(rst_b), .redirect(redirect), .redirect_pc(redirect_pc), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0]   exp_q [$];
  logic [AW-1:0] ram_addr_q [$];
  int            ram_rdy_q [$];
  bit            slow = 0, hold = 0, fetch_chk_en = 0;
  logic [AW-1:0] exp_fetch = '0;
  int            age = 0;
  bit            held_vld = 0;
  logic [AW-1:0] held_addr = '0;
  int            acc_cnt = 0, fire_cnt = 0, streak = 0, last_fire = -10;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0001);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // RAM responder: drives a little after the edge so stimulus changes made at +1 are seen.
  always @(posedge clk) begin
    #2;
    if (!rst_b) begin
      bus.instr_addr_ok = 1'b0;
      bus.instr_data_ok = 1'b0;
      bus.instr_rdata   = '0;
    end else begin
      bus.instr_addr_ok = slow ? (age >= 2) : 1'b1;
      if (!hold && ram_addr_q.size() > 0 && ram_rdy_q[0] <= cyc) begin
        bus.instr_data_ok = 1'b1;
        bus.instr_rdata   = mem_word(ram_addr_q.pop_front());
        void'(ram_rdy_q.pop_front());
      end else begin
        bus.instr_data_ok = 1'b0;
        bus.instr_rdata   = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      ram_addr_q.delete();
      ram_rdy_q.delete();
      age      = 0;
      held_vld = 0;
    end else begin
      if (held_vld) begin
        chk("req_hold", 64'(bus.instr_req), 64'd1);
        chk("addr_hold", 64'(bus.instr_addr), 64'(held_addr));
      end
      if (bus.instr_req && bus.instr_addr_ok) begin
        acc_cnt++;
        ram_addr_q.push_back(bus.instr_addr);
        ram_rdy_q.push_back(cyc + 1);
        if (fetch_chk_en) begin
          chk("fetch_addr", 64'(bus.instr_addr), 64'(exp_fetch));
          exp_fetch++;
        end
        age = 0;
      end else if (bus.instr_req) age++;
      else age = 0;
      held_vld  = bus.instr_req && !bus.instr_addr_ok;
      held_addr = bus.instr_addr;
    end
  end

  // Output monitor: pops the scoreboard on every decode handshake.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_b && bus.out_valid && bus.out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual=%0h expected=none", {bus.out_pc, bus.out_instr});
      end else begin
        e = exp_q.pop_front();
        chk("out_pc_instr", {bus.out_pc, bus.out_instr}, e);
      end
      fire_cnt++;
      streak    = (last_fire == cyc - 1) ? streak + 1 : 1;
      last_fire = cyc;
    end
  end

  task automatic push_stream(input logic [31:0] pc0, input int n);
    logic [31:0] pc;
    logic [AW-1:0] wa;
    for (int i = 0; i < n; i++) begin
      pc = pc0 + 32'(4 * i);
      wa = pc[AW+1:2];
      exp_q.push_back({pc, mem_word(wa)});
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    bus.out_ready = 1'b0;
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect    = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("req_rel0", 64'(bus.instr_req), 64'd0);
    @(negedge clk);
    chk("req_rel1", 64'(bus.instr_req), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0; redirect = 1'b0; redirect_pc = '0; bus.out_ready = 1'b0;
    idle(3);
    chk("rst_req", 64'(bus.instr_req), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("tie_write", 64'({bus.instr_write, bus.instr_wstrb, bus.instr_wdata}), 64'd0);

    // 1: streaming at one instruction per cycle
    push_stream(32'h0, 8);
    bus.out_ready = 1'b1;
    fetch_chk_en  = 1'b1;
    release_reset();
    wait_drain("t1_drain");
    chk("t1_rate", 64'(streak), 64'd8);

    // 2: back-pressure fills the FIFO, then drains in order
    idle(20);
    chk("t2_req_idle", 64'(bus.instr_req), 64'd0);
    chk("t2_buffered", 64'(acc_cnt - fire_cnt), 64'd4);
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    push_stream(32'h20, 8);
    bus.out_ready = 1'b1;
    wait_drain("t2_drain");

    // 3: slow address acceptance
    slow = 1'b1;
    push_stream(32'h40, 6);
    bus.out_ready = 1'b1;
    wait_drain("t3_drain");
    idle(20);
    slow = 1'b0;

    // 4: redirect with two requests in flight
    hold = 1'b1;
    idle(20);
    fetch_chk_en = 1'b0;
    do_redirect(32'h80);
    idle(4);
    chk("t4_req_full", 64'(bus.instr_req), 64'd0);
    do_redirect(32'h100);
    hold = 1'b0;
    push_stream(32'h100, 8);
    bus.out_ready = 1'b1;
    wait_drain("t4_drain");

    // 5: redirects while a request is pending, back to back
    idle(20);
    slow = 1'b1;
    idle(2);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h180;
    @(posedge clk); #1;
    redirect_pc = 32'h300;
    chk("t5_req_pend", 64'(bus.instr_req), 64'd1);
    @(posedge clk); #1;
    redirect_pc = 32'h200;
    chk("t5_addr_held", 64'(bus.instr_addr), 64'h60);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("t5_flush", 64'(bus.out_valid), 64'd0);
    push_stream(32'h200, 6);
    bus.out_ready = 1'b1;
    wait_drain("t5_drain");

    // 6: asynchronous reset with two in flight and a buffered word
    slow = 1'b0;
    idle(20);
    hold = 1'b1;
    do_redirect(32'h400);
    idle(4);
    hold = 1'b0;
    idle(1);
    hold = 1'b1;
    idle(4);
    chk("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    chk("t6_pre_req", 64'(bus.instr_req), 64'd0);
    @(posedge clk); #3;
    rst_b = 1'b0;
    #1;
    chk("t6_rst_req", 64'(bus.instr_req), 64'd0);
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    idle(3);
    hold = 1'b0;
    push_stream(32'h0, 6);
    exp_fetch     = '0;
    fetch_chk_en  = 1'b1;
    bus.out_ready = 1'b1;
    release_reset();
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
